alu_sequencer: RTL
==================

# alu_sequencer

Issue controller that shares one `alu_with_register_file` datapath between two instruction requesters. It arbitrates round-robin, latches the winning 26-bit instruction, and drives it onto the datapath for a fixed execute window. It then samples `out`/`overflow`/`c_out` and returns them to the granted requester through a valid/ready response channel. One instruction is in flight at a time.

## Interface
- `EXEC_CYCLES`, default 1: cycles the instruction is held on the datapath before results are sampled. Legal range is 1..15.
- `IDLE_INSTR`, default 26'h0: value driven on `alu_instruction` when nothing is issued.

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_instr0`, `req_instr1`  in  26 each  instruction: [25:24] op_code, [23:0] register-file field.
- `req_ready`  out  2  one-hot accept; the instruction is taken when `req_valid[i] & req_ready[i]`.
- `alu_instruction`  out  26  to datapath `instruction`.
- `alu_issue`  out  1  one-cycle strobe on the first execute cycle.
- `alu_out`  in  16; `alu_overflow`  in  1; `alu_c_out`  in  1: datapath results.
- `rsp_valid`  out  1; `rsp_ready`  in  1: response handshake.
- `rsp_id`  out  1  requester index of the response.
- `rsp_out`  out  16; `rsp_overflow`  out  1; `rsp_c_out`  out  1: captured results.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE → EXEC when a request is accepted.
  - EXEC → RESP when the execute counter expires.
  - RESP → IDLE on `rsp_valid & rsp_ready`.
- Arbitration happens in IDLE only.
  - `req_ready` is combinational from state, `req_valid` and `last_grant`.
  - Only one requester valid: that requester is granted.
  - Both valid: grant `~last_grant`.
  - `last_grant` updates on accept.
- Accept:
  - Latch the instruction and `rsp_id` = grant.
  - Load the counter with `EXEC_CYCLES-1`.
- EXEC:
  - `alu_instruction` = latched instruction.
  - Counter decrements each cycle.
  - On the cycle the counter is 0, `alu_out`/`alu_overflow`/`alu_c_out` are registered into the `rsp_*` regs and the state moves to RESP.
- RESP:
  - `rsp_valid`=1.
  - All `rsp_*` outputs are held stable until `rsp_ready`.
  - `alu_instruction` = `IDLE_INSTR`.
- The instruction is not modified. Result width is 16 bits exactly as the datapath produces it; no sign or zero extension.
- `req_ready` is 0 in EXEC and RESP regardless of `req_valid`. Requesters hold `valid` and `instr` stable until accepted.

## Timing
- Reset values (async, `reset_n`=0):
  - state IDLE; `last_grant`=1, so requester 0 wins first.
  - `req_ready`=0 while `reset_n` is low.
  - `alu_instruction`=`IDLE_INSTR`; `alu_issue`=0.
  - `rsp_valid`=0; `rsp_id`, `rsp_out`, `rsp_overflow`, `rsp_c_out`=0; `busy`=0.
- Cycle numbering, with accept at cycle T:
  - T+1 … T+EXEC_CYCLES: EXEC. `alu_issue`=1 at T+1 only.
  - Results are sampled at the clock edge that ends cycle T+EXEC_CYCLES.
  - T+EXEC_CYCLES+1: `rsp_valid`=1.
- Response timing:
  - If `rsp_ready` is already high, the handshake completes in that cycle and the state is IDLE the next cycle.
  - The next accept is possible in that IDLE cycle.
  - Minimum spacing between accepts is EXEC_CYCLES+2 cycles.
- `rsp_ready` held low: the state stays in RESP indefinitely, with no further accepts.
- Reset asserted mid-transaction: the transaction is dropped with no response. After release the block is in IDLE, and a requester that is still valid is re-arbitrated from `last_grant`=1.
- `req_valid` deasserting in IDLE before grant: no accept, no state change.

## Structure
- Package `alu_ctrl_pkg` holds:
  - Constants: `INSTR_W`=26, `OP_W`=2, `OP_LSB`=24, `RESULT_W`=16, `CNT_W`=4.
  - The state typedef (IDLE/EXEC/RESP).
- One sub-module, `rr_arbiter2`: inputs `req[1:0]`, `last_grant`, `enable`; output one-hot `grant[1:0]`.
- Top is the `alu_sequencer` FSM, counter and latches. It instantiates alongside `alu_with_register_file` in the parent; it does not contain it.

## Test plan
- Reset then single request: `req_valid`=01, `req_instr0`=26'h1_0A_05_03, `EXEC_CYCLES`=1, `rsp_ready`=1.
  - `req_ready`=01 at T.
  - `alu_instruction`=26'h10A0503 and `alu_issue`=1 at T+1.
  - `rsp_valid`=1, `rsp_id`=0 at T+2, with `rsp_out` equal to the `alu_out` driven at T+1.
- Contention: both valid continuously for 4 transactions → `rsp_id` sequence 0,1,0,1. `req_ready` is never two-hot.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_*` stable throughout.
  - `req_ready`=00 and `busy`=1 throughout.
  - Release → IDLE next cycle.
- `EXEC_CYCLES`=3 with the model changing `alu_out` 16'h0001/0002/0003 across EXEC → `rsp_out`=16'h0003. The overflow and carry inputs set on the last cycle only appear on `rsp_overflow`/`rsp_c_out`.
- Reset pulse in EXEC → all outputs return to reset values asynchronously. No `rsp_valid` for the aborted transaction. The first post-reset grant goes to requester 0 when both are valid.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared widths and FSM state type for the ALU issue controller.
package alu_ctrl_pkg;

    localparam int INSTR_W  = 26;
    localparam int OP_W     = 2;
    localparam int OP_LSB   = 24;
    localparam int RESULT_W = 16;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, contention goes to the
// requester that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one ALU/register-file datapath between two requesters: arbitrates,
// holds the instruction for a fixed execute window, then returns the results.
module alu_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int                  EXEC_CYCLES = 1,
    parameter logic [INSTR_W-1:0]  IDLE_INSTR  = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    input  logic [INSTR_W-1:0]  req_instr0,
    input  logic [INSTR_W-1:0]  req_instr1,
    output logic [1:0]          req_ready,
    output logic [INSTR_W-1:0]  alu_instruction,
    output logic                alu_issue,
    input  logic [RESULT_W-1:0] alu_out,
    input  logic                alu_overflow,
    input  logic                alu_c_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [RESULT_W-1:0] rsp_out,
    output logic                rsp_overflow,
    output logic                rsp_c_out,
    output logic                busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RESULT_W-1:0]   rsp_out_q, rsp_out_d;
    logic                  rsp_overflow_q, rsp_overflow_d;
    logic                  rsp_c_out_q, rsp_c_out_d;
    logic                  issue_q, issue_d;

    logic                  arb_enable;
    logic [1:0]            grant;
    logic                  accept;
    logic                  grant_id;

    // Reset is folded in so no requester sees a grant while the block is held in reset.
    assign arb_enable = (state_q == IDLE) && reset_n;

    rr_arbiter2 u_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .enable     (arb_enable),
        .grant      (grant)
    );

    assign accept   = |(req_valid & grant);
    assign grant_id = grant[1];

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        instr_d        = instr_q;
        rsp_id_d       = rsp_id_q;
        cnt_d          = cnt_q;
        rsp_out_d      = rsp_out_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_c_out_d    = rsp_c_out_q;
        issue_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    last_grant_d = grant_id;
                    rsp_id_d     = grant_id;
                    instr_d      = grant_id ? req_instr1 : req_instr0;
                    cnt_d        = CNT_LOAD;
                    issue_d      = 1'b1;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d        = RESP;
                    rsp_out_d      = alu_out;
                    rsp_overflow_d = alu_overflow;
                    rsp_c_out_d    = alu_c_out;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            instr_q        <= '0;
            rsp_id_q       <= 1'b0;
            cnt_q          <= '0;
            rsp_out_q      <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_c_out_q    <= 1'b0;
            issue_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            instr_q        <= instr_d;
            rsp_id_q       <= rsp_id_d;
            cnt_q          <= cnt_d;
            rsp_out_q      <= rsp_out_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_c_out_q    <= rsp_c_out_d;
            issue_q        <= issue_d;
        end
    end

    always_comb begin
        req_ready       = grant;
        alu_instruction = (state_q == EXEC) ? instr_q : IDLE_INSTR;
        alu_issue       = issue_q;
        rsp_valid       = (state_q == RESP);
        rsp_id          = rsp_id_q;
        rsp_out         = rsp_out_q;
        rsp_overflow    = rsp_overflow_q;
        rsp_c_out       = rsp_c_out_q;
        busy            = (state_q != IDLE);
    end

endmodule
